// File: rtl/node_table_search.sv
// Walks a length-prefixed node-ID table in memory and reports first-match index or match count.
// Latency: 2 cycles to read the length, then 2 cycles per entry; done pulses one cycle after the last compare.
// Backpressure: none; memory is assumed to return data one cycle after address, start is ignored while busy.
module node_table_search #(
  parameter int unsigned WORD_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned TABLE_BASE  = 0,
  parameter int unsigned ADDR_STRIDE = 2,
  parameter int unsigned MAX_ENTRIES = 32,
  parameter int unsigned IDX_WIDTH   = $clog2(MAX_ENTRIES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [WORD_WIDTH-1:0] key,
  input  logic [WORD_WIDTH-1:0] mem_data_out,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [IDX_WIDTH-1:0]  match_index,
  output logic [IDX_WIDTH:0]    match_count,
  output logic                  error
);

  localparam int unsigned CW = IDX_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(TABLE_BASE);
  localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(ADDR_STRIDE);
  localparam logic [WORD_WIDTH-1:0] MAX_W    = WORD_WIDTH'(MAX_ENTRIES);

  typedef enum logic [2:0] {IDLE, RD_LEN, LEN, RD_ENT, CMP, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] key_q, key_d;
  logic                  mode_q, mode_d;
  logic [CW-1:0]         n_q, n_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic                  found_q, found_d;
  logic [IDX_WIDTH-1:0]  mi_q, mi_d;
  logic [CW-1:0]         mc_q, mc_d;
  logic                  err_q, err_d;
  logic                  last_ent;

  // The entry being compared is the final one when idx equals N-1.
  assign last_ent = ({1'b0, idx_q} == (n_q - CW'(1)));

  // State and result registers; reset returns everything to idle with cleared results.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= BASE_A;
      key_q   <= '0;
      mode_q  <= 1'b0;
      n_q     <= '0;
      idx_q   <= '0;
      found_q <= 1'b0;
      mi_q    <= '0;
      mc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      found_q <= found_d;
      mi_q    <= mi_d;
      mc_q    <= mc_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath updates; every register holds unless its state changes it.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    key_d   = key_q;
    mode_d  = mode_q;
    n_d     = n_q;
    idx_d   = idx_q;
    found_d = found_q;
    mi_d    = mi_q;
    mc_d    = mc_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key;
          mode_d  = mode;
          found_d = 1'b0;
          mi_d    = '0;
          mc_d    = '0;
          err_d   = 1'b0;
          addr_d  = BASE_A;
          state_d = RD_LEN;
        end
      end
      RD_LEN: state_d = LEN;
      LEN: begin
        if (mem_data_out == '0) begin
          state_d = DONE;
        end else if (mem_data_out > MAX_W) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          // Length is known to fit in CW bits here.
          n_d     = mem_data_out[CW-1:0];
          idx_d   = '0;
          addr_d  = BASE_A + STRIDE_A;
          state_d = RD_ENT;
        end
      end
      RD_ENT: state_d = CMP;
      CMP: begin
        if (mem_data_out == key_q) begin
          found_d = 1'b1;
          if (!mode_q) begin
            mi_d = idx_q;
            mc_d = CW'(1);
          end else begin
            mc_d = mc_q + CW'(1);
          end
        end
        if ((mem_data_out == key_q && !mode_q) || last_ent) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_WIDTH'(1);
          addr_d  = addr_q + STRIDE_A;
          state_d = RD_ENT;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign address     = addr_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign found       = found_q;
  assign match_index = mi_q;
  assign match_count = mc_q;
  assign error       = err_q;

endmodule

// File: tb/tb_node_table_search.sv
// Bench for node_table_search: table of search vectors plus reset and start-while-busy sequences.
// Latency: checks the exact edge at which done appears relative to the accepting start edge.
// Backpressure: none; a word memory model answers every address one cycle later.
module tb_node_table_search;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        mode  = 1'b0;
  logic [15:0] key   = '0;
  logic [15:0] mem_data_out;
  logic [15:0] address;
  logic        busy, done, found, error;
  logic [4:0]  match_index;
  logic [5:0]  match_count;

  node_table_search dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .key(key),
    .mem_data_out(mem_data_out), .address(address), .busy(busy), .done(done),
    .found(found), .match_index(match_index), .match_count(match_count), .error(error)
  );

  always #5 clock = ~clock;

  // Word memory: byte address / 2 selects a word, one-cycle read latency.
  logic [15:0] mem_words [64];
  logic [5:0]  mem_idx;
  assign mem_idx = 6'(address >> 1);
  always @(posedge clock) mem_data_out <= mem_words[mem_idx];

  typedef struct {
    int          n;
    logic [15:0] ent [8];
    logic [15:0] k;
    logic        m;
    logic        f;
    int          idx;
    int          cnt;
    logic        err;
    int          edge_n;
  } vec_t;

  typedef struct {
    logic f;
    int   idx;
    int   cnt;
    logic err;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  logic [15:0] ent_tmp [8];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int n, input logic [15:0] k, input logic m, input logic f,
                     input int idx, input int cnt, input logic err, input int edg);
    vec_t v;
    v.n = n; v.ent = ent_tmp; v.k = k; v.m = m; v.f = f;
    v.idx = idx; v.cnt = cnt; v.err = err; v.edge_n = edg;
    vecs.push_back(v);
  endtask

  // Scoreboard: each done pulse pops the oldest expectation and checks the held results.
  always @(negedge clock) begin
    if (reset && done) begin
      if (sb.size() == 0) begin
        chk("sb_empty_at_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("found", int'(found), int'(e.f));
        chk("match_index", int'(match_index), e.idx);
        chk("match_count", int'(match_count), e.cnt);
        chk("error", int'(error), int'(e.err));
      end
    end
  end

  task automatic load_and_start(input vec_t v);
    exp_t e;
    for (int i = 0; i < 64; i++) mem_words[i] = 16'hFFFF;
    mem_words[0] = v.n[15:0];
    for (int i = 0; i < 8; i++) mem_words[1+i] = v.ent[i];
    e.f = v.f; e.idx = v.idx; e.cnt = v.cnt; e.err = v.err;
    @(negedge clock);
    key   = v.k;
    mode  = v.m;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clock);  // E0
    #1;
    start = 1'b0;
    key   = ~key;      // changes after acceptance must not matter
    mode  = ~mode;
  endtask

  task automatic run_vec(input vec_t v, input int pulse_edge);
    int   k;
    int   got;
    logic moved;
    logic busy_at_done;
    load_and_start(v);
    k = 0; got = -1; moved = 1'b0; busy_at_done = 1'b0;
    while (got < 0 && k < 200) begin
      @(posedge clock);
      k++;
      #1;
      start = (k + 1 == pulse_edge);
      @(negedge clock);
      if (address != 16'd0) moved = 1'b1;
      if (done) begin
        got = k;
        busy_at_done = busy;
      end
    end
    start = 1'b0;
    chk("done_edge", got, v.edge_n);
    if (got < 0) sb.delete();
    chk("busy_at_done", int'(busy_at_done), 1);
    if (v.err) chk("no_entry_read", int'(moved), 0);
    @(negedge clock);
    chk("done_single_cycle", int'(done), 0);
    chk("busy_fall", int'(busy), 0);
    chk("found_hold", int'(found), int'(v.f));
    chk("count_hold", int'(match_count), v.cnt);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_found"}, int'(found), 0);
    chk({tag, "_idx"}, int'(match_index), 0);
    chk({tag, "_count"}, int'(match_count), 0);
    chk({tag, "_error"}, int'(error), 0);
    chk({tag, "_address"}, int'(address), 0);
  endtask

  initial begin
    ent_tmp = '{16'd2, 16'd5, 16'd9, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    add(3, 16'd5, 1'b0, 1'b1, 1, 1, 1'b0, 6);
    ent_tmp = '{16'd5, 16'd1, 16'd5, 16'd5, 16'd0, 16'd0, 16'd0, 16'd0};
    add(4, 16'd5, 1'b1, 1'b1, 0, 3, 1'b0, 10);
    ent_tmp = '{16'd2, 16'd7, 16'd9, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    add(3, 16'd17, 1'b0, 1'b0, 0, 0, 1'b0, 8);
    add(0, 16'd2, 1'b0, 1'b0, 0, 0, 1'b0, 2);
    add(40, 16'd2, 1'b1, 1'b0, 0, 0, 1'b1, 2);
    add(33, 16'd2, 1'b0, 1'b0, 0, 0, 1'b1, 2);
    ent_tmp = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    add(32, 16'hFFFF, 1'b1, 1'b1, 0, 24, 1'b0, 66);
    ent_tmp = '{16'd7, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    add(1, 16'd7, 1'b0, 1'b1, 0, 1, 1'b0, 4);
    ent_tmp = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd9, 16'd0, 16'd0, 16'd0};
    add(5, 16'd9, 1'b0, 1'b1, 4, 1, 1'b0, 12);
    ent_tmp = '{16'd1, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    add(2, 16'd3, 1'b1, 1'b0, 0, 0, 1'b0, 6);
    ent_tmp = '{16'h0005, 16'h8005, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    add(2, 16'h8005, 1'b0, 1'b1, 1, 1, 1'b0, 6);

    for (int i = 0; i < 64; i++) mem_words[i] = '0;
    #12;
    chk_reset_vals("por");
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], -1);

    // Reset asserted mid-search at E4, then a fresh search must complete correctly.
    load_and_start(vecs[0]);
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
    run_vec(vecs[0], -1);

    // Start pulse sampled at E3 of a running search must be ignored.
    run_vec(vecs[0], 3);
    run_vec(vecs[1], 3);

    repeat (3) @(negedge clock);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
